// File: rtl/pq_pkg.sv
// Shared key/value, heap-entry and control types for the pipelined heap.
// Ordering helpers treat inactive entries as smaller than any active one.
package pq_pkg;

  localparam int LEVELS = 4;
  localparam int KW = 8;
  localparam int VW = 8;
  localparam int CW = LEVELS;

  localparam logic [KW-1:0] KEY0 = '0;
  localparam logic [VW-1:0] VAL0 = '0;

  typedef struct packed {
    logic [KW-1:0] key;
    logic [VW-1:0] val;
  } kv_t;

  typedef struct packed {
    kv_t           kv;
    logic [CW-1:0] capacity;
    logic          active;
  } entry_t;

  localparam kv_t KV_EMPTY = '{key: KEY0, val: VAL0};
  localparam entry_t ENTRY_EMPTY =
    '{kv: KV_EMPTY, capacity: '0, active: 1'b0};

  typedef enum logic [1:0] {
    OP_NOP  = 2'd0,
    LEQ     = 2'd1,
    DEQ     = 2'd2,
    ENQ_DEQ = 2'd3
  } opcode_t;

  typedef enum logic [1:0] {
    DONE       = 2'd0,
    WAIT       = 2'd1,
    NEXT_LEVEL = 2'd2
  } done_t;

  function automatic logic cmp_kv_entry_gt(
    input kv_t a, input entry_t b);
    return !b.active || (a.key > b.kv.key);
  endfunction

  function automatic logic cmp_entry_entry_gt(
    input entry_t a, input entry_t b);
    return a.active &&
      (!b.active || (a.kv.key > b.kv.key));
  endfunction

endpackage

// File: rtl/pheap_level_if.sv
// Request/response bundle between adjacent heap levels.
// Master is the upstream stage, slave the level being driven.
interface pheap_level_if
  import pq_pkg::*;
#(
  parameter int LVL = 2
);

  logic           start;
  opcode_t        op;
  kv_t            kv_in;
  logic [LVL-2:0] addr_in;
  logic           active;
  done_t          done;
  logic [LVL-1:0] addr_out;
  kv_t            kv_out;

  modport master (
    output start, op, kv_in, addr_in,
    input  active, done, addr_out, kv_out
  );

  modport slave (
    input  start, op, kv_in, addr_in,
    output active, done, addr_out, kv_out
  );

endinterface

// File: rtl/pheap_level.sv
// One non-root level of a pipelined heap: latches a request, then
// updates one node and forwards the displaced value downstream.
module pheap_level
  import pq_pkg::*;
#(
  parameter int LVL = 2,
  localparam int NODES = 2 ** (LVL - 1),
  localparam int IW = LVL - 1,
  localparam int PW = (LVL > 2) ? LVL - 2 : 1
) (
  input  logic          clk,
  input  logic          rst,
  pheap_level_if.slave  bus,
  input  logic [PW-1:0] raddr_top_i,
  output entry_t        r_top_l_o,
  output entry_t        r_top_r_o,
  output logic [IW-1:0] raddr_bot_o,
  input  entry_t        r_bot_l_i,
  input  entry_t        r_bot_r_i
);

  localparam logic [CW-1:0] CAP =
    CW'((1 << (LEVELS - LVL + 1)) - 1);
  localparam logic [CW-1:0] ONE = CW'(1);
  localparam entry_t INIT =
    '{kv: KV_EMPTY, capacity: CAP, active: 1'b0};

  typedef enum logic {
    S_IDLE,
    S_EXEC
  } state_t;

  state_t        state_q;
  opcode_t       op_q;
  kv_t           kv_q;
  logic [IW-1:0] idx_q;
  entry_t        mem_q [NODES];

  entry_t         t;
  entry_t         t_d;
  logic           we;
  logic           l_gt_r;
  logic           end_pos;
  logic           l_nz;
  logic           r_nz;
  logic           act;
  done_t          dn;
  kv_t            kv_out;
  logic [LVL-1:0] addr_out;
  logic [CW-1:0]  cap_dec;
  logic [CW-1:0]  cap_inc;

  always_comb begin
    t        = mem_q[idx_q];
    t_d      = t;
    we       = 1'b0;
    end_pos  = 1'b0;
    act      = 1'b0;
    dn       = DONE;
    kv_out   = KV_EMPTY;
    addr_out = '0;
    l_gt_r   = cmp_entry_entry_gt(r_bot_l_i, r_bot_r_i);
    l_nz     = r_bot_l_i.capacity != '0;
    r_nz     = r_bot_r_i.capacity != '0;
    cap_dec  = (t.capacity == '0) ? '0 : t.capacity - ONE;
    cap_inc  = (t.capacity >= CAP) ? CAP : t.capacity + ONE;
    if (state_q == S_IDLE) begin
      if (bus.start) begin
        act = 1'b1;
        dn  = WAIT;
      end
    end else begin
      act = 1'b1;
      unique case (1'b1)
        op_q == LEQ: begin
          we           = 1'b1;
          t_d.capacity = cap_dec;
          t_d.active   = 1'b1;
          if (!t.active) begin
            t_d.kv = kv_q;
          end else begin
            dn = NEXT_LEVEL;
            if (cmp_kv_entry_gt(kv_q, t)) begin
              t_d.kv = kv_q;
              kv_out = t.kv;
            end else begin
              kv_out = kv_q;
            end
            // Steer toward a child that still has room.
            if (l_nz && r_nz) end_pos = l_gt_r;
            else if (l_nz)    end_pos = 1'b0;
            else              end_pos = 1'b1;
          end
        end
        op_q == DEQ: begin
          we           = 1'b1;
          t_d.capacity = cap_inc;
          if (!r_bot_l_i.active && !r_bot_r_i.active) begin
            t_d.kv     = KV_EMPTY;
            t_d.active = 1'b0;
          end else begin
            t_d.kv     = l_gt_r ? r_bot_l_i.kv : r_bot_r_i.kv;
            t_d.active = 1'b1;
            end_pos    = !l_gt_r;
            dn         = NEXT_LEVEL;
          end
        end
        op_q == ENQ_DEQ: begin
          we         = 1'b1;
          t_d.active = 1'b1;
          if (cmp_kv_entry_gt(kv_q, r_bot_l_i) &&
              cmp_kv_entry_gt(kv_q, r_bot_r_i)) begin
            t_d.kv = kv_q;
          end else begin
            t_d.kv  = l_gt_r ? r_bot_l_i.kv : r_bot_r_i.kv;
            end_pos = !l_gt_r;
            kv_out  = kv_q;
            dn      = NEXT_LEVEL;
          end
        end
        default: begin
          we = 1'b0;
        end
      endcase
      addr_out = {idx_q, end_pos};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      op_q    <= OP_NOP;
      kv_q    <= KV_EMPTY;
      idx_q   <= '0;
      for (int i = 0; i < NODES; i++) begin
        mem_q[i] <= INIT;
      end
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (bus.start) begin
            state_q <= S_EXEC;
            op_q    <= bus.op;
            kv_q    <= bus.kv_in;
            idx_q   <= bus.addr_in;
          end
        end
        default: begin
          state_q <= S_IDLE;
          if (we) mem_q[idx_q] <= t_d;
        end
      endcase
    end
  end

  assign bus.active   = act;
  assign bus.done     = dn;
  assign bus.kv_out   = kv_out;
  assign bus.addr_out = addr_out;
  assign raddr_bot_o  = idx_q;

  generate
    if (LVL == 2) begin : g_top_pair
      logic unused_raddr;
      assign unused_raddr = ^raddr_top_i;
      assign r_top_l_o = mem_q[0];
      assign r_top_r_o = mem_q[1];
    end else begin : g_top_idx
      assign r_top_l_o = mem_q[{raddr_top_i, 1'b0}];
      assign r_top_r_o = mem_q[{raddr_top_i, 1'b1}];
    end
  endgenerate

endmodule

// File: tb/tb_pheap_level.sv
// Bench for heap level 2 of a 4-level heap: directed vectors plus
// random ops scored against a rank-based model of the node rules.
module tb_pheap_level;
  import pq_pkg::*;

  localparam int LVL = 2;
  localparam logic [CW-1:0] CAP = 7;

  logic   clk = 1'b0;
  logic   rst = 1'b0;
  logic   raddr_top = 1'b0;
  entry_t r_top_l, r_top_r, r_bot_l, r_bot_r;
  logic   raddr_bot;
  int     checks = 0;
  int     errors = 0;
  entry_t mdl [2];

  always #5 clk = ~clk;

  pheap_level_if #(.LVL(LVL)) bus ();

  pheap_level #(.LVL(LVL)) dut (
    .clk(clk), .rst(rst), .bus(bus),
    .raddr_top_i(raddr_top),
    .r_top_l_o(r_top_l), .r_top_r_o(r_top_r),
    .raddr_bot_o(raddr_bot),
    .r_bot_l_i(r_bot_l), .r_bot_r_i(r_bot_r)
  );

  function automatic entry_t mk(int k, int v, int c, bit a);
    entry_t e;
    e.kv.key   = KW'(k);
    e.kv.val   = VW'(v);
    e.capacity = CW'(c);
    e.active   = a;
    return e;
  endfunction

  function automatic kv_t mkv(int k, int v);
    kv_t x;
    x.key = KW'(k);
    x.val = VW'(v);
    return x;
  endfunction

  // Inactive entries rank below every real key.
  function automatic int rank(entry_t e);
    return e.active ? int'(e.kv.key) : -1;
  endfunction

  function automatic void ref_exec(
    input opcode_t op, input kv_t kin, input entry_t t,
    input entry_t l, input entry_t r,
    output entry_t nt, output done_t d, output kv_t o,
    output logic ep);
    int rl, rr, ki;
    rl = rank(l);
    rr = rank(r);
    ki = int'(kin.key);
    nt = t;
    d  = DONE;
    o  = KV_EMPTY;
    ep = 1'b0;
    case (op)
      LEQ: begin
        nt.capacity = (t.capacity == 0) ? '0 : t.capacity - CW'(1);
        nt.active = 1'b1;
        if (!t.active) nt.kv = kin;
        else begin
          d = NEXT_LEVEL;
          if (ki > int'(t.kv.key)) begin
            nt.kv = kin;
            o = t.kv;
          end else o = kin;
          if (l.capacity != 0 && r.capacity != 0) ep = rl > rr;
          else ep = (l.capacity == 0);
        end
      end
      DEQ: begin
        nt.capacity = (t.capacity >= CAP) ? CAP : t.capacity + CW'(1);
        if (rl < 0 && rr < 0) begin
          nt.kv = KV_EMPTY;
          nt.active = 1'b0;
        end else begin
          ep = !(rl > rr);
          nt.kv = ep ? r.kv : l.kv;
          nt.active = 1'b1;
          d = NEXT_LEVEL;
        end
      end
      ENQ_DEQ: begin
        nt.active = 1'b1;
        if (ki > rl && ki > rr) nt.kv = kin;
        else begin
          ep = !(rl > rr);
          nt.kv = ep ? r.kv : l.kv;
          o = kin;
          d = NEXT_LEVEL;
        end
      end
      default: ;
    endcase
  endfunction

  task automatic run_op(
    input opcode_t op, input kv_t kin, input logic idx,
    input entry_t l, input entry_t r,
    output done_t d_wait, output logic a_wait,
    output done_t d_exec, output kv_t o_exec,
    output logic [1:0] ao_exec, output entry_t pre);
    @(negedge clk);
    bus.start   = 1'b1;
    bus.op      = op;
    bus.kv_in   = kin;
    bus.addr_in = idx;
    r_bot_l     = l;
    r_bot_r     = r;
    #1;
    d_wait = bus.done;
    a_wait = bus.active;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    @(negedge clk);
    d_exec  = bus.done;
    o_exec  = bus.kv_out;
    ao_exec = bus.addr_out;
    pre     = idx ? r_top_r : r_top_l;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++;
    if (bus.active !== 1'b0 || bus.done !== DONE ||
        bus.kv_out !== KV_EMPTY || bus.addr_out !== 2'd0 ||
        raddr_bot !== 1'b0) begin
      errors++;
      $display("FAIL reset_outputs: got act=%0b done=%0d out=%h ao=%0d rb=%0d required 0 0 0 0 0",
               bus.active, bus.done, bus.kv_out, bus.addr_out, raddr_bot);
    end
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    checks++;
    if (r_top_l !== mk(0, 0, 7, 0) || r_top_r !== mk(0, 0, 7, 0)) begin
      errors++;
      $display("FAIL reset_mem: got %h %h required %h",
               r_top_l, r_top_r, mk(0, 0, 7, 0));
    end
    checks++;
    if (bus.active !== 1'b0 || bus.done !== DONE) begin
      errors++;
      $display("FAIL reset_idle: got act=%0b done=%0d required 0 0",
               bus.active, bus.done);
    end
    mdl[0] = mk(0, 0, 7, 0);
    mdl[1] = mk(0, 0, 7, 0);
  endtask

  task automatic test_vectors();
    done_t dw, de;
    logic aw;
    kv_t oe;
    logic [1:0] ao;
    entry_t pre;
    run_op(LEQ, mkv(5, 1), 1'b1, mk(0, 0, 3, 0), mk(0, 0, 3, 0),
           dw, aw, de, oe, ao, pre);
    checks++;
    if (dw !== WAIT || aw !== 1'b1 || de !== DONE) begin
      errors++;
      $display("FAIL leq_empty_done: got %0d %0b %0d required 1 1 0", dw, aw, de);
    end
    checks++;
    if (r_top_r !== mk(5, 1, 6, 1)) begin
      errors++;
      $display("FAIL leq_empty_mem: got %h required %h", r_top_r, mk(5, 1, 6, 1));
    end
    run_op(LEQ, mkv(9, 2), 1'b1, mk(0, 0, 3, 0), mk(0, 0, 2, 0),
           dw, aw, de, oe, ao, pre);
    checks++;
    if (de !== NEXT_LEVEL || oe !== mkv(5, 1) || ao !== 2'd2 ||
        r_top_r !== mk(9, 2, 5, 1)) begin
      errors++;
      $display("FAIL leq_swap: got d=%0d o=%h ao=%0d m=%h required 2 %h 2 %h",
               de, oe, ao, r_top_r, mkv(5, 1), mk(9, 2, 5, 1));
    end
    checks++;
    if (pre !== mk(5, 1, 6, 1)) begin
      errors++;
      $display("FAIL read_pre_write: got %h required %h", pre, mk(5, 1, 6, 1));
    end
    run_op(DEQ, mkv(0, 0), 1'b1, mk(4, 3, 1, 1), mk(7, 4, 1, 1),
           dw, aw, de, oe, ao, pre);
    checks++;
    if (de !== NEXT_LEVEL || oe !== KV_EMPTY || ao !== 2'd3 ||
        r_top_r !== mk(7, 4, 6, 1)) begin
      errors++;
      $display("FAIL deq_child: got d=%0d o=%h ao=%0d m=%h required 2 0 3 %h",
               de, oe, ao, r_top_r, mk(7, 4, 6, 1));
    end
    run_op(ENQ_DEQ, mkv(3, 5), 1'b1, mk(4, 3, 1, 1), mk(7, 6, 1, 1),
           dw, aw, de, oe, ao, pre);
    checks++;
    if (de !== NEXT_LEVEL || oe !== mkv(3, 5) || ao !== 2'd3 ||
        r_top_r !== mk(7, 6, 6, 1)) begin
      errors++;
      $display("FAIL enqdeq_down: got d=%0d o=%h ao=%0d m=%h required 2 %h 3 %h",
               de, oe, ao, r_top_r, mkv(3, 5), mk(7, 6, 6, 1));
    end
    run_op(ENQ_DEQ, mkv(8, 7), 1'b1, mk(4, 3, 1, 1), mk(7, 6, 1, 1),
           dw, aw, de, oe, ao, pre);
    checks++;
    if (de !== DONE || oe !== KV_EMPTY || r_top_r !== mk(8, 7, 6, 1)) begin
      errors++;
      $display("FAIL enqdeq_stay: got d=%0d o=%h m=%h required 0 0 %h",
               de, oe, r_top_r, mk(8, 7, 6, 1));
    end
    run_op(DEQ, mkv(0, 0), 1'b1, mk(0, 0, 3, 0), mk(0, 0, 3, 0),
           dw, aw, de, oe, ao, pre);
    checks++;
    if (de !== DONE || r_top_r !== mk(0, 0, 7, 0)) begin
      errors++;
      $display("FAIL deq_leaf: got d=%0d m=%h required 0 %h",
               de, r_top_r, mk(0, 0, 7, 0));
    end
    run_op(DEQ, mkv(0, 0), 1'b0, mk(0, 0, 3, 0), mk(0, 0, 3, 0),
           dw, aw, de, oe, ao, pre);
    checks++;
    if (r_top_l !== mk(0, 0, 7, 0)) begin
      errors++;
      $display("FAIL deq_cap_sat: got %h required %h", r_top_l, mk(0, 0, 7, 0));
    end
    mdl[0] = mk(0, 0, 7, 0);
    mdl[1] = mk(0, 0, 7, 0);
  endtask

  task automatic test_back_to_back();
    @(negedge clk);
    bus.start   = 1'b1;
    bus.op      = LEQ;
    bus.kv_in   = mkv(33, 3);
    bus.addr_in = 1'b0;
    @(posedge clk);
    #1;
    bus.kv_in   = mkv(99, 9);
    bus.addr_in = 1'b1;
    @(negedge clk);
    checks++;
    if (bus.done !== DONE || bus.active !== 1'b1) begin
      errors++;
      $display("FAIL b2b_exec: got d=%0d a=%0b required 0 1", bus.done, bus.active);
    end
    @(posedge clk);
    #1 bus.start = 1'b0;
    @(negedge clk);
    checks++;
    if (bus.active !== 1'b0 || r_top_l !== mk(33, 3, 6, 1) ||
        r_top_r !== mk(0, 0, 7, 0)) begin
      errors++;
      $display("FAIL b2b_ignored: got a=%0b l=%h r=%h required 0 %h %h",
               bus.active, r_top_l, r_top_r, mk(33, 3, 6, 1), mk(0, 0, 7, 0));
    end
    mdl[0] = mk(33, 3, 6, 1);
  endtask

  task automatic test_random(int n);
    done_t dw, de, xd;
    logic aw, xep, idx;
    kv_t oe, xo, kin;
    logic [1:0] ao;
    entry_t pre, nt, l, r;
    opcode_t op;
    int sel;
    for (int i = 0; i < n; i++) begin
      idx = 1'($urandom_range(0, 1));
      kin = mkv(int'($urandom_range(0, 255)), int'($urandom_range(0, 255)));
      l = mk(int'($urandom_range(0, 255)), int'($urandom_range(0, 255)),
             int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
      r = mk(int'($urandom_range(0, 255)), int'($urandom_range(0, 255)),
             int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
      sel = int'($urandom_range(0, 9));
      if (sel == 0) op = OP_NOP;
      else if (sel <= 4) op = LEQ;
      else if (sel <= 7) op = DEQ;
      else op = mdl[idx].active ? ENQ_DEQ : LEQ;
      ref_exec(op, kin, mdl[idx], l, r, nt, xd, xo, xep);
      run_op(op, kin, idx, l, r, dw, aw, de, oe, ao, pre);
      checks++;
      if (dw !== WAIT || aw !== 1'b1 || pre !== mdl[idx]) begin
        errors++;
        $display("FAIL rnd_issue %0d: got %0d %0b %h required 1 1 %h",
                 i, dw, aw, pre, mdl[idx]);
      end
      checks++;
      if (de !== xd || oe !== xo ||
          (xd == NEXT_LEVEL && ao !== {idx, xep})) begin
        errors++;
        $display("FAIL rnd_out %0d op=%0d: got d=%0d o=%h ao=%0d required %0d %h %0d",
                 i, op, de, oe, ao, xd, xo, {idx, xep});
      end
      mdl[idx] = nt;
      checks++;
      if (r_top_l !== mdl[0] || r_top_r !== mdl[1]) begin
        errors++;
        $display("FAIL rnd_mem %0d op=%0d: got %h %h required %h %h",
                 i, op, r_top_l, r_top_r, mdl[0], mdl[1]);
      end
    end
  endtask

  task automatic test_reset_in_exec();
    @(negedge clk);
    bus.start   = 1'b1;
    bus.op      = LEQ;
    bus.kv_in   = mkv(200, 1);
    bus.addr_in = 1'b1;
    @(posedge clk);
    #1 bus.start = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    checks++;
    if (r_top_l !== mk(0, 0, 7, 0) || r_top_r !== mk(0, 0, 7, 0) ||
        bus.active !== 1'b0 || bus.done !== DONE) begin
      errors++;
      $display("FAIL rst_in_exec: got l=%h r=%h a=%0b d=%0d required %h %h 0 0",
               r_top_l, r_top_r, bus.active, bus.done,
               mk(0, 0, 7, 0), mk(0, 0, 7, 0));
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout required finish");
    $fatal(1, "timeout");
  end

  initial begin
    bus.start   = 1'b0;
    bus.op      = OP_NOP;
    bus.kv_in   = KV_EMPTY;
    bus.addr_in = 1'b0;
    r_bot_l     = ENTRY_EMPTY;
    r_bot_r     = ENTRY_EMPTY;
    test_reset();
    test_vectors();
    test_back_to_back();
    test_random(300);
    test_reset_in_exec();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pheap_level.md
PHEAP_LEVEL -- requirements
Module: pheap_level

Interface
REQ-001 Parameter LVL, default 2, meaning heap level implemented, 2..LEVELS; level 1 is the root stage.
REQ-002 Derived constants: NODES = 2^(LVL-1); IW = LVL-1 (node index width); PW = max(1, LVL-2) (pair index width); CAP = 2^(LEVELS-LVL+1)-1 (subtree capacity); LEVELS, kv_t, entry_t, opcode_t and done_t come from pq_pkg/pheapTypes.
REQ-003 clk  in  1  sole clock; all state updates on rising edge.
REQ-004 rst  in  1  reset, synchronous, active-high.
REQ-005 start  in  1  upstream request; upstream done==NEXT_LEVEL.
REQ-006 op  in  opcode_t  LEQ, DEQ or ENQ_DEQ.
REQ-007 in  in  kv_t  value passed down (don't-care for DEQ).
REQ-008 addrIn  in  IW  index of target node in this level.
REQ-009 rBotL, rBotR  in  entry_t  children of latched node, read from level LVL+1; tied to ENTRY_EMPTY (capacity 0, inactive) when LVL==LEVELS.
REQ-010 raddrTop  in  PW  pair index read by upstream stage.
REQ-011 rTopL, rTopR  out  entry_t  mem[{raddrTop,0}], mem[{raddrTop,1}], combinational; for LVL==2, mem[0], mem[1].
REQ-012 raddrBot  out  IW  latched node index, driven to level LVL+1 as its raddrTop.
REQ-013 active  out  1  stage busy.
REQ-014 done  out  done_t  DONE, WAIT or NEXT_LEVEL.
REQ-015 addrOut  out  LVL  {latched index, endPos}; downstream addrIn.
REQ-016 out  out  kv_t  value passed to level LVL+1; KV_EMPTY unless NEXT_LEVEL.

Function
REQ-017 Storage: NODES entries of entry_t {kv, capacity, active}, one write port, two combinational read ports.
REQ-018 FSM states IDLE and EXEC; IDLE->EXEC on start, EXEC->IDLE unconditionally; start in EXEC ignored.
REQ-019 IDLE with start: latch op, in, addrIn; active=1, done=WAIT; no memory write.
REQ-020 IDLE without start: active=0, done=DONE, out=KV_EMPTY, no write.
REQ-021 EXEC: active=1; node T=mem[latched index]; at most one write of T, committed at the EXEC clock edge; outputs combinational in EXEC; latency start->result one cycle.
REQ-022 Comparisons use cmp_kv_entry_gt / cmp_entry_entry_gt; an inactive entry compares less than any active one.
REQ-023 LEQ, T inactive: T <= {in, T.capacity-1, active=1}; done=DONE.
REQ-024 LEQ, T active: larger of in/T.kv stays, smaller drives out; capacity saturating-decrement at 0; done=NEXT_LEVEL.
REQ-025 LEQ endPos: both children capacity!=0 -> 0 unless L_gt_R, then 1; only left capacity!=0 -> 0; otherwise 1.
REQ-026 DEQ: capacity+1 saturating at CAP; no active child -> T.kv={KEY0,VAL0}, active=0, done=DONE; else T.kv=larger child (L_gt_R -> left, ties right), endPos=that child, done=NEXT_LEVEL, out=KV_EMPTY.
REQ-027 ENQ_DEQ: in > both children -> T.kv=in, done=DONE; else T.kv=larger child not less than in, endPos=that child, out=in, done=NEXT_LEVEL; capacity unchanged.
REQ-028 Any other op in EXEC: no write, done=DONE.
REQ-029 rTopL/rTopR during the EXEC write edge return pre-write contents; new value visible next cycle.

Reset
REQ-030 rst forces IDLE in the same edge and reinitialises every entry to {{KEY0,VAL0}, CAP, 0}, overriding any in-flight EXEC write.
REQ-031 During and after reset until start: active=0, done=DONE, out=KV_EMPTY, addrOut=0, raddrBot=0.

Verification (LEVELS=4, LVL=2, CAP=7, children capacity 3)
REQ-032 Reset then read raddrTop=0 -> rTopL=rTopR={0,7,0}; active=0, done=DONE.
REQ-033 LEQ in=5, addrIn=1 into empty node -> cycle1 done=WAIT, cycle2 done=DONE; mem[1]={5,6,1}.
REQ-034 LEQ in=9 at node {5,6,1}, children caps 3/2, L_gt_R=0 -> mem[1]={9,5,1}, out=5, addrOut=2, done=NEXT_LEVEL.
REQ-035 DEQ at node {9,5,1}, rBotL={4,1,1}, rBotR={7,1,1} -> mem[1]={7,6,1}, addrOut=3, done=NEXT_LEVEL; both children inactive -> active=0, cap+1, done=DONE.
REQ-036 ENQ_DEQ in=3, children 4 and 7 -> T=7, out=3, addrOut=3; in=8 -> T=8, done=DONE.
REQ-037 rst in EXEC of an LEQ -> no write, next cycle IDLE, entry {0,7,0}; start during EXEC -> ignored.
